pid_block_assembler: RTL

Upstream neighbour of the 128-bit AES input packer. Collects the eight 16-bit PID control outputs, which arrive serially with a channel tag, and assembles them into one 128-bit plaintext block. Presents the block to the AES core over a valid/ready handshake. Double-buffered (assembly register plus output register), so collection of the next block overlaps AES consumption of the current one.

---
 rtl/pid_block_assembler.sv | 89 ++++++++
 1 files changed

// File: rtl/pid_block_assembler.sv
// pid_block_assembler: collects eight tagged 16-bit PID samples into one double-buffered 128-bit block for the AES core.
//   clk, rst               : clock and synchronous active-high reset
//   s_valid/s_ready        : sample handshake; s_chan tags the channel, s_data is the sample
//   m_valid/m_ready/m_data : block handshake; channel 0 in [127:112], channel 7 in [15:0]
//   blk_count              : delivered blocks, wrapping
//   seq_err/err_count      : one-cycle pulse per out-of-order tag, saturating error count
module pid_block_assembler #(
  parameter int DW  = 16,
  parameter int NCH = 8,
  parameter int CW  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [CW-1:0]     s_chan,
  input  logic [DW-1:0]     s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DW*NCH-1:0] m_data,
  output logic [15:0]       blk_count,
  output logic              seq_err,
  output logic [7:0]        err_count
);
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] FULL = 1'b1;
  logic [0:0]        asm_full_q, asm_full_d;
  logic [CW-1:0]     exp_idx_q, exp_idx_d;
  logic [DW*NCH-1:0] asm_q, asm_d, m_data_q;
  logic              m_valid_q, seq_err_q, seq_err_d;
  logic [15:0]       blk_count_q;
  logic [7:0]        err_count_q, err_count_d;
  logic              xfer, s_acc, in_seq, last;
  // While FULL, exp_idx is already 0, so a sample arriving on the transfer cycle is handled as the start of a new block.
  always_comb begin
    xfer        = (asm_full_q == FULL) & (~m_valid_q | m_ready);
    s_ready     = (asm_full_q == FILL) | xfer;
    s_acc       = s_valid & s_ready;
    in_seq      = s_chan == exp_idx_q;
    last        = exp_idx_q == CW'(NCH-1);
    asm_d       = asm_q;
    asm_full_d  = xfer ? FILL : asm_full_q;
    exp_idx_d   = exp_idx_q;
    seq_err_d   = 1'b0;
    err_count_d = err_count_q;
    // In-order samples land in slot s_chan; an out-of-order tag 0 restarts the block in slot 0.
    if (s_acc & (in_seq | s_chan == '0))
      asm_d[DW*(NCH-1-int'(s_chan)) +: DW] = s_data;
    if (s_acc & in_seq) begin
      exp_idx_d  = last ? '0 : exp_idx_q + CW'(1);
      asm_full_d = last ? FULL : asm_full_d;
    end
    if (s_acc & ~in_seq) begin
      seq_err_d   = 1'b1;
      err_count_d = err_count_q + {7'd0, err_count_q != 8'hFF};
      exp_idx_d   = (s_chan == '0) ? CW'(1) : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_full_q  <= FILL;
      exp_idx_q   <= '0;
      asm_q       <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      blk_count_q <= '0;
      seq_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      asm_full_q  <= asm_full_d;
      exp_idx_q   <= exp_idx_d;
      asm_q       <= asm_d;
      seq_err_q   <= seq_err_d;
      err_count_q <= err_count_d;
      if (xfer) begin
        m_data_q  <= asm_q;
        m_valid_q <= 1'b1;
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end
      if (m_valid_q & m_ready) blk_count_q <= blk_count_q + 16'd1;
    end
  end
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign blk_count = blk_count_q;
  assign seq_err   = seq_err_q;
  assign err_count = err_count_q;
endmodule
